// File: rtl/morse_pkg.sv
// Shared Morse definitions for the lab-board letter transmitter and receiver:
// letter codes, left-justified dot/dash patterns (1 = dash) and symbol lengths.
package morse_pkg;

    typedef enum logic [2:0] {
        LTR_A = 3'd0,
        LTR_B = 3'd1,
        LTR_C = 3'd2,
        LTR_D = 3'd3,
        LTR_E = 3'd4,
        LTR_F = 3'd5,
        LTR_G = 3'd6,
        LTR_H = 3'd7
    } letter_e;

    // Mark lengths in Morse units; a space inside a letter is one unit.
    localparam int DOT_UNITS  = 1;
    localparam int DASH_UNITS = 3;

    localparam logic [3:0] PAT_A = 4'b0100;
    localparam logic [3:0] PAT_B = 4'b1000;
    localparam logic [3:0] PAT_C = 4'b1010;
    localparam logic [3:0] PAT_D = 4'b1000;
    localparam logic [3:0] PAT_E = 4'b0000;
    localparam logic [3:0] PAT_F = 4'b0010;
    localparam logic [3:0] PAT_G = 4'b1100;
    localparam logic [3:0] PAT_H = 4'b0000;

    localparam logic [2:0] LEN_A = 3'd2;
    localparam logic [2:0] LEN_B = 3'd4;
    localparam logic [2:0] LEN_C = 3'd4;
    localparam logic [2:0] LEN_D = 3'd3;
    localparam logic [2:0] LEN_E = 3'd1;
    localparam logic [2:0] LEN_F = 3'd4;
    localparam logic [2:0] LEN_G = 3'd3;
    localparam logic [2:0] LEN_H = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_EMIT,
        ST_ERR
    } rx_state_e;

    function automatic logic [3:0] pattern_of(input letter_e l);
        case (l)
            LTR_A:   return PAT_A;
            LTR_B:   return PAT_B;
            LTR_C:   return PAT_C;
            LTR_D:   return PAT_D;
            LTR_E:   return PAT_E;
            LTR_F:   return PAT_F;
            LTR_G:   return PAT_G;
            default: return PAT_H;
        endcase
    endfunction

    function automatic logic [2:0] length_of(input letter_e l);
        case (l)
            LTR_A:   return LEN_A;
            LTR_B:   return LEN_B;
            LTR_C:   return LEN_C;
            LTR_D:   return LEN_D;
            LTR_E:   return LEN_E;
            LTR_F:   return LEN_F;
            LTR_G:   return LEN_G;
            default: return LEN_H;
        endcase
    endfunction

endpackage

// File: rtl/morse_rx_if.sv
// Tone line in, decoded letter and status pulses out of the Morse receiver.
interface morse_rx_if;
    logic       morse_in;
    logic [2:0] letter;
    logic       valid;
    logic       err;
    logic       busy;

    modport master (output morse_in, input letter, valid, err, busy);
    modport slave  (input morse_in, output letter, valid, err, busy);
endinterface

// File: rtl/morse_lut.sv
// Combinational reverse lookup from a received (pattern, length) pair to a letter.
module morse_lut
    import morse_pkg::*;
(
    input  logic [3:0] code,
    input  logic [2:0] len,
    output logic [2:0] letter,
    output logic       hit
);

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        letter = 3'd0;
        hit    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (code == pattern_of(letter_e'(3'(i))) && len == length_of(letter_e'(3'(i)))) begin
                letter = 3'(i);
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_rx.sv
// Morse receiver: synchronises the tone line, times marks and spaces, and
// decodes letters A-H into the transmitter's 3-bit switch code.
module morse_rx
    import morse_pkg::*;
#(
    parameter int TICK_CYCLES = 25000000,
    parameter int CNT_W       = 28
) (
    input  logic      clk,
    input  logic      clear,
    morse_rx_if.slave bus
);

    localparam logic [CNT_W-1:0] DOT_MAX  = CNT_W'(2 * TICK_CYCLES);
    localparam logic [CNT_W-1:0] DASH_MAX = CNT_W'(5 * TICK_CYCLES);
    localparam logic [CNT_W-1:0] GAP_MIN  = CNT_W'(2 * TICK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       code_q, code_d;
    logic [2:0]       len_q, len_d;
    logic [2:0]       letter_q, letter_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             sync1_q, m_s_q;
    logic [2:0]       lut_letter;
    logic             lut_hit;
    logic [1:0]       bit_idx;

    morse_lut u_lut (
        .code   (code_q),
        .len    (len_q),
        .letter (lut_letter),
        .hit    (lut_hit)
    );

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
    assign bit_idx = 2'(3'd3 - len_q);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            sync1_q  <= 1'b0;
            m_s_q    <= 1'b0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            code_q   <= '0;
            len_q    <= '0;
            letter_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sync1_q  <= bus.morse_in;
            m_s_q    <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            len_q    <= len_d;
            letter_q <= letter_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (m_s_q) begin
                    state_d = ST_MARK;
                    cnt_d   = CNT_ONE;
                    code_d  = '0;
                    len_d   = '0;
                end
            end
            ST_MARK: begin
                if (m_s_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= DASH_MAX) begin
                        state_d = ST_ERR;
                        cnt_d   = '0;
                    end
                end else if (len_q == 3'd4) begin
                    // The mark just ended counts as the first quiet cycle of the error gap.
                    state_d = ST_ERR;
                    cnt_d   = CNT_ONE;
                end else begin
                    code_d[bit_idx] = (cnt_q >= DOT_MAX);
                    len_d           = len_q + 3'd1;
                    state_d         = ST_SPACE;
                    cnt_d           = CNT_ONE;
                end
            end
            ST_SPACE: begin
                if (m_s_q) begin
                    state_d = ST_MARK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= GAP_MIN) state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            ST_ERR: begin
                if (m_s_q) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= GAP_MIN) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // EMIT leads to IDLE only, so a lookup pulse can never coincide with an ERR-entry pulse.
    always_comb begin
        valid_d  = (state_q == ST_EMIT) && lut_hit;
        err_d    = ((state_q == ST_EMIT) && !lut_hit) ||
                   ((state_q != ST_ERR) && (state_d == ST_ERR));
        letter_d = valid_d ? lut_letter : letter_q;
    end

    assign bus.letter = letter_q;
    assign bus.valid  = valid_q;
    assign bus.err    = err_q;
    assign bus.busy   = (state_q != ST_IDLE);

endmodule

// File: doc/morse_rx.md
Name: morse_rx

Overview:
- Morse receiver: the far end of the letter transmitter on the lab board.
- Samples a single tone line (1 = tone on) and measures mark and space durations in clock cycles. Classifies each mark as dot or dash and detects the end of a letter.
- Decodes letters A–H into the same 3-bit code (A=000 … H=111) that the transmitter takes from SW[2:0]. Flags malformed input as an error.
- Intended use: loopback test of the transmitter (LEDR[0] -> morse_in), with letter shown on HEX/LEDR.

Parameters:
- TICK_CYCLES, 25000000, clock cycles per Morse unit (0.5 s at 50 MHz); dot = 1 unit, dash = 3 units, intra-letter space = 1 unit.
- CNT_W, 28, duration counter width; must hold 5*TICK_CYCLES.
- Derived localparams (not overridable):
  - DOT_MAX = 2*TICK_CYCLES
  - DASH_MAX = 5*TICK_CYCLES
  - GAP_MIN = 2*TICK_CYCLES

Ports:
- clk, input, 1, system clock (CLOCK_50).
- clear, input, 1, asynchronous active-low reset.
- morse_in, input, 1, asynchronous tone line, 1 = mark.
- letter, output, 3, last successfully decoded letter, held until the next valid.
- valid, output, 1, one-cycle pulse when letter updates.
- err, output, 1, one-cycle pulse on a malformed or undecodable letter.
- busy, output, 1, high whenever state is not IDLE.

Behaviour:
- Reset:
  - clear=0 asynchronously forces state=IDLE.
  - cnt, code[3:0], len[2:0], letter, valid, err, busy and both sync flops all go to 0.
  - Reset mid-letter discards the partial letter with no pulse.
- Synchronizer: 2-flop sync of morse_in to m_s. All decisions use m_s, so 2 cycles of input latency.
- cnt: counts cycles within the current mark or space. It is set to 1 on entry to MARK or SPACE, increments every cycle while the level holds, and saturates at all-ones.
- IDLE:
  - m_s=1 -> MARK with code=0, len=0.
  - Otherwise stay in IDLE.
- MARK:
  - m_s=1: increment cnt. If cnt reaches DASH_MAX -> ERR.
  - m_s=0 (classify): bit = (cnt >= DOT_MAX).
    - If len==4 -> ERR (5th symbol).
    - Else code[3-len] = bit, len = len+1, -> SPACE.
- SPACE:
  - m_s=1 -> MARK (next symbol).
  - m_s=0: increment cnt. When cnt reaches GAP_MIN -> EMIT.
- EMIT (one cycle):
  - Look up (code, len).
  - Hit: letter <= match, valid=1.
  - Miss: err=1, letter unchanged.
  - Then -> IDLE.
- ERR:
  - err=1 for exactly the first cycle in ERR.
  - Stay in ERR until m_s has been 0 for GAP_MIN consecutive cycles, then -> IDLE.
  - Any mark inside ERR restarts the gap count. No valid is produced.
- Code table: code is left-justified, 1 = dash, unused low bits = 0.
  - A len2 01
  - B len4 1000
  - C len4 1010
  - D len3 100
  - E len1 0
  - F len4 0010
  - G len3 110
  - H len4 0000
- Latency: valid/err pulse = sync 2 + GAP_MIN + 1 cycles after the last mark's falling edge on morse_in.
- valid and err are never both high in the same cycle. Neither pulses while clear=0.

Decomposition:
- Shared package morse_pkg, also used by the transmitter:
  - letter code constants A..H
  - per-letter pattern[3:0] and length[2:0] constants
  - unit-multiple constants 1 and 3
- One combinational sub-module, morse_lut: inputs (code, len), outputs (letter[2:0], hit). It is driven from the package constants.
- The FSM, counter and synchronizer live in morse_rx.

Test Plan (TICK_CYCLES=10, so DOT_MAX=20, DASH_MAX=50, GAP_MIN=20):
1. Reset: hold clear=0, toggle morse_in -> letter=000, valid=0, err=0, busy=0 throughout. Release -> busy=0 until the first mark.
2. 'A': 10 high, 10 low, 30 high, 40 low -> exactly one valid with letter=000, 23 cycles after the last falling edge; busy then returns to 0.
3. 'H' (4×(10 high, 10 low)), then 'E' (10 high) with 40-cycle gaps -> valid with letter=111, then valid with letter=100; no err.
4. Undecodable dash-dash (30 high, 10 low, 30 high, 40 low) -> one err pulse, no valid, letter keeps its previous value.
5. Stuck mark of 80 high -> err pulses when cnt reaches 50. After 20 low cycles state returns to IDLE; no valid. Five dots -> err on the 5th falling edge.
6. Loopback from the transmitter at the same TICK_CYCLES for SW=000..111 -> letters decode in order. Asserting clear mid-MARK -> busy=0 immediately and no pulse follows.
